// File: rtl/nibble_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_serial_adder : byte-wide add/sub, one nibble per clock, LSN first |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module nibble_serial_adder #(
  parameter int NIBBLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sub,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  output logic [4*NIBBLES:0]   sum,
  output logic               busy,
  output logic               done
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic            r_sub;
  logic [W-1:0]    r_opa;
  logic [W-1:0]    r_opb;
  logic [W-1:0]    r_res;

  logic [3:0]      w_na;
  logic [3:0]      w_nb;
  logic [4:0]      w_ns;
  logic            w_last;

  // Select the current nibble pair; the loop keeps every slice a constant range.
  always_comb begin
    w_na = '0;
    w_nb = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == IW'(i)) begin
        w_na = r_opa[4*i +: 4];
        w_nb = r_opb[4*i +: 4];
      end
    end
  end

  assign w_ns   = {1'b0, w_na} + {1'b0, w_nb} + {4'b0000, r_carry};
  assign w_last = (r_idx == IW'(NIBBLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      sum     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            // Subtract is A + ~B + 1: the +1 enters as the initial carry.
            r_opa   <= A;
            r_opb   <= sub ? ~B : B;
            r_sub   <= sub;
            r_carry <= sub;
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= ADD;
          end
        end
        ADD: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IW'(i)) begin
              r_res[4*i +: 4] <= w_ns[3:0];
            end
          end
          r_carry <= w_ns[4];
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_state <= FIN;
          end
        end
        FIN: begin
          sum     <= {r_carry, r_res};
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// Directed self-checking bench for nibble_serial_adder (NIBBLES = 2).
module tb_nibble_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sub;
  logic [7:0] A;
  logic [7:0] B;
  logic [8:0] sum;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  nibble_serial_adder #(.NIBBLES(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .sum   (sum),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands on a falling edge, hold start for exactly one rising edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    A = a; B = b; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns with done sampled high #1 after its edge, or after the budget expires.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    int seen;
    int cyc;
    #1;
    tests++;
    if (sum !== 9'h000 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_init: sum=%h busy=%b done=%b, want 000/0/0", sum, busy, done);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL reset_idle: %0d cycles with done/busy high, want 0", seen);
    end
    issue(8'h12, 8'h34, 1'b0);
    wait_done(cyc);
    tests++;
    if (done !== 1'b1 || sum !== 9'h046) begin
      fails++;
      $display("FAIL reset_preop: done=%b sum=%h, want 1/046", done, sum);
    end
    // Assert reset between edges: outputs must clear without a clock edge.
    @(negedge clk); #2 rst = 1'b1; #1;
    tests++;
    if (sum !== 9'h000 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: sum=%h busy=%b done=%b, want 000/0/0", sum, busy, done);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_add_latency();
    issue(8'h3C, 8'h5A, 1'b0);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL lat_edge0: busy=%b done=%b, want 1/0", busy, done);
    end
    for (int e = 1; e <= 2; e++) begin
      @(posedge clk); #1;
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL lat_edge%0d: busy=%b done=%b, want 1/0", e, busy, done);
      end
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== 9'h096) begin
      fails++;
      $display("FAIL lat_edge3: done=%b busy=%b sum=%h, want 1/0/096", done, busy, sum);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || sum !== 9'h096) begin
      fails++;
      $display("FAIL lat_hold: done=%b sum=%h, want 0/096", done, sum);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [4] = '{8'hFF, 8'hFF, 8'h50, 8'h20};
    logic [7:0] vb [4] = '{8'h01, 8'hFF, 8'h20, 8'h50};
    logic       vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [8:0] ve [4] = '{9'h100, 9'h1FE, 9'h130, 9'h0D0};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i], vs[i]);
      wait_done(cyc);
      tests++;
      if (done !== 1'b1 || sum !== ve[i]) begin
        fails++;
        $display("FAIL vec%0d: %h %s %h gives done=%b sum=%h, want 1/%h",
                 i, va[i], vs[i] ? "-" : "+", vb[i], done, sum, ve[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    issue(8'h3C, 8'h5A, 1'b0);
    A = 8'h11; B = 8'h11; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    tests++;
    if (done !== 1'b1 || sum !== 9'h096) begin
      fails++;
      $display("FAIL busy_ignore: done=%b sum=%h, want 1/096", done, sum);
    end
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_ignore_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    issue(8'h3C, 8'h5A, 1'b0);
    wait_done(cyc);
    A = 8'h01; B = 8'h02; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || sum !== 9'h096) begin
      fails++;
      $display("FAIL b2b_accept: busy=%b done=%b sum=%h, want 1/0/096", busy, done, sum);
    end
    wait_done(cyc);
    tests++;
    if (done !== 1'b1 || sum !== 9'h003 || cyc != 3) begin
      fails++;
      $display("FAIL b2b_second: done=%b sum=%h cycles=%0d, want 1/003/3", done, sum, cyc);
    end
  endtask

  task automatic test_reset_midop();
    int seen;
    issue(8'hFF, 8'h01, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    tests++;
    if (busy !== 1'b0 || sum !== 9'h000 || done !== 1'b0) begin
      fails++;
      $display("FAIL midop_reset: busy=%b sum=%h done=%b, want 0/000/0", busy, sum, done);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL midop_quiet: %0d cycles with done/busy high, want 0", seen);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    test_reset();
    test_add_latency();
    test_vectors();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
